muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit with its own HI/LO register pair for the MIPS 5-stage pipeline. It is parametrised in operand width. It sits beside the ALU in the EXE stage and is launched by a one-cycle `start` from EXE. It reports `busy` so the hazard logic can stall any later HI/LO reader or new mul/div. It also reports a real divide-by-zero flag, which replaces the tied-off `math_divide_zero` path.

## Interface
- `DATA_BITS`, default 32: operand, HI and LO width; must be ≥ 2.
- `clk`  in  1  main clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  stage enable; when 0, all state holds, including the iteration counter.
- `start`  in  1  launch request, sampled at a rising edge while `en` = 1.
- `cancel`  in  1  exception flush; aborts any operation in progress.
- `oper`  in  3  operation code: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MSUB.
- `a`, `b`  in  DATA_BITS each  operands (RS, RT).
- `busy`  out  1  high while state ≠ IDLE.
- `hi`, `lo`  out  DATA_BITS each  architectural HI and LO registers.
- `divide_zero`  out  1  registered one-cycle pulse.

## Operation
- FSM states:
  - IDLE → RUN on an accepted MULT, MULTU, DIV, DIVU, MADD or MSUB.
  - RUN → FIX when the counter reaches DATA_BITS−1.
  - FIX → IDLE unconditionally.
- Priority at each edge: `rst` > `cancel` > `en` = 0 (hold) > `start`.
- `start` is accepted only in IDLE. A `start` while busy is ignored; the controller must stall.
- On accept, signed ops latch |a| and |b| plus the result sign bits. Unsigned ops latch raw operands.
- Multiply: shift-add, one bit per cycle, 2·DATA_BITS-bit product.
- Divide: restoring, one quotient bit per cycle.
  - Quotient → LO, remainder → HI.
  - Quotient sign = a⊕b; remainder sign = sign of a.
  - Most-negative ÷ −1 wraps: LO = 0x8000_0000, HI = 0 (for DATA_BITS = 32); no flag.
- FIX applies the negations and writes HI/LO. MADD/MSUB write {HI,LO} ± signed product, mod 2^(2·DATA_BITS).
- DIV/DIVU with b = 0:
  - No RUN phase; HI/LO unchanged.
  - `divide_zero` = 1 for exactly the cycle after the accepting edge; `busy` stays 0.
- MTHI/MTLO write `a` into HI or LO at the accepting edge; `busy` stays 0. Accepted only in IDLE.
- `cancel` in RUN or FIX: return to IDLE at that edge. HI/LO keep their pre-operation values, because FIX's write is suppressed.
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `divide_zero` = 0; state IDLE, counter 0. A reset mid-operation discards the operation.

## Timing
- Accepting edge E0: `busy` = 1 from E0 through E0 + DATA_BITS + 1, i.e. DATA_BITS + 1 cycles. HI/LO hold new values after E0 + DATA_BITS + 1.
- For DATA_BITS = 32 the latency is 33 cycles.
- `en` = 0 stretches latency by one cycle per disabled cycle.
- MTHI/MTLO: new value visible one cycle after E0.
- `busy` is registered; the controller stalls on `busy` OR (`start` AND mul/div `oper`).

## Configuration
- `MULDIV_MADD_EN` defined: MD_MADD/MD_MSUB accumulate as described above.
- `MULDIV_MADD_EN` undefined:
  - MD_MADD/MD_MSUB are accepted as no-ops: no state change, `busy` stays 0.
  - The accumulate adder is not built.

## Structure
- MD_* opcodes go in the shared `mips_define.vh` header, next to the existing EXE/WB encodings.
- Also in `mips_define.vh`: state encodings MD_IDLE, MD_RUN, MD_FIX.
- One natural sub-module, `muldiv_core`: the shift/subtract datapath and counter. The top level keeps the FSM, sign handling, HI/LO and the MADD adder.

## Test plan
- MULT a = 0xFFFF_FFFD (−3), b = 7 → `busy` high exactly 33 cycles, then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB.
- DIVU a = 100, b = 7 → LO = 14, HI = 2. DIV a = −7, b = 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIV a = 5, b = 0 with HI/LO = 0x11/0x22:
  - `divide_zero` pulses for one cycle, `busy` never rises.
  - HI/LO stay 0x11/0x22.
- MULTU 0xFFFF_FFFF × 2 with `cancel` at cycle 10 → `busy` drops next cycle, HI/LO unchanged. Repeat with `rst` at cycle 10 → HI = LO = 0.
- With HI/LO = 0/5, MADD a = 2, b = 3:
  - Macro defined → LO = 11, HI = 0.
  - Macro undefined → LO = 5, `busy` never rises.
- `start` (MTLO a = 9) during a running DIVU → ignored; DIVU result correct and LO ≠ 9. Hold `en` = 0 for 4 cycles mid-RUN → `busy` lasts 37 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Opcodes, controller states and decode helpers shared by the muldiv unit.
// MULDIV_MADD_EN selects whether MADD/MSUB start a real accumulate.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    // Operations that occupy the iterative datapath (divide-by-zero is filtered separately).
    function automatic logic md_is_long(input md_op_e op);
`ifdef MULDIV_MADD_EN
        return (op != MD_MTHI) && (op != MD_MTLO);
`else
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Magnitude datapath: shift-add multiply and restoring divide, one bit per step,
// plus the step counter that flags the final iteration to the controller.
module muldiv_core #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         last_o,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   b_q;
    logic           div_q;
    logic [CW-1:0]  cnt_q;
    logic [W:0]     add_sum, shifted, diff;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        add_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        shifted = {acc_q[2*W-1:W], acc_q[W-1]};
        diff    = shifted - {1'b0, b_q};
        acc_d   = {add_sum, acc_q[W-1:1]};
        if (div_q) begin
            if (diff[W]) begin
                acc_d = {shifted[W-1:0], acc_q[W-2:0], 1'b0};
            end else begin
                acc_d = {diff[W-1:0], acc_q[W-2:0], 1'b1};
            end
        end
    end

    assign last_o = (cnt_q == CW'(W - 1));
    assign hi_o   = acc_q[2*W-1:W];
    assign lo_o   = acc_q[W-1:0];

    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (rst_i) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{W{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= last_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with its own HI/LO pair for the EXE stage.
// Define MULDIV_MADD_EN to build the MADD/MSUB accumulate path.
module muldiv
    import muldiv_pkg::*;
#(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 start_i,
    input  logic                 cancel_i,
    input  logic [2:0]           oper_i,
    input  logic [DATA_BITS-1:0] a_i,
    input  logic [DATA_BITS-1:0] b_i,
    output logic                 busy_o,
    output logic [DATA_BITS-1:0] hi_o,
    output logic [DATA_BITS-1:0] lo_o,
    output logic                 divide_zero_o
);

    localparam int W = DATA_BITS;

    md_state_e      state_q;
    md_op_e         op_q;
    md_op_e         op;
    logic           busy_q, divide_zero_q;
    logic           neg_lo_q, neg_hi_q;
    logic [W-1:0]   hi_q, lo_q;

    logic           sign_a, sign_b, launch, step;
    logic [W-1:0]   mag_a, mag_b;
    logic           core_last;
    logic [W-1:0]   core_hi, core_lo;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s;

    assign op = md_op_e'(oper_i);

    always_comb begin
        sign_a = md_is_signed(op) & a_i[W-1];
        sign_b = md_is_signed(op) & b_i[W-1];
        mag_a  = sign_a ? -a_i : a_i;
        mag_b  = sign_b ? -b_i : b_i;
        launch = en_i & ~cancel_i & start_i & (state_q == MD_IDLE)
               & md_is_long(op) & ~(md_is_div(op) & (b_i == '0));
        step   = en_i & ~cancel_i & (state_q == MD_RUN);
    end

    muldiv_core #(.W(W)) u_core (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (launch),
        .step_i (step),
        .div_i  (md_is_div(op)),
        .a_i    (mag_a),
        .b_i    (mag_b),
        .last_o (core_last),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    // Sign restoration: neg_lo covers product and quotient, neg_hi the remainder.
    always_comb begin
        prod_s = neg_lo_q ? -{core_hi, core_lo} : {core_hi, core_lo};
        quo_s  = neg_lo_q ? -core_lo : core_lo;
        rem_s  = neg_hi_q ? -core_hi : core_hi;
    end

`ifdef MULDIV_MADD_EN
    logic [2*W-1:0] madd_res;

    always_comb begin
        madd_res = (op_q == MD_MSUB) ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= MD_IDLE;
            op_q          <= MD_MULT;
            busy_q        <= 1'b0;
            divide_zero_q <= 1'b0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            divide_zero_q <= 1'b0;
            if (cancel_i) begin
                state_q <= MD_IDLE;
                busy_q  <= 1'b0;
            end else if (en_i) begin
                case (state_q)
                    MD_IDLE: begin
                        if (launch) begin
                            state_q  <= MD_RUN;
                            busy_q   <= 1'b1;
                            op_q     <= op;
                            neg_lo_q <= sign_a ^ sign_b;
                            neg_hi_q <= sign_a;
                        end else if (start_i) begin
                            if (op == MD_MTHI) hi_q <= a_i;
                            if (op == MD_MTLO) lo_q <= a_i;
                            // A divide that did not launch can only be a zero divisor.
                            divide_zero_q <= md_is_div(op);
                        end
                    end
                    MD_RUN: begin
                        if (core_last) state_q <= MD_FIX;
                    end
                    MD_FIX: begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                        case (op_q)
                            MD_MULT, MD_MULTU: {hi_q, lo_q} <= prod_s;
                            MD_DIV, MD_DIVU: begin
                                lo_q <= quo_s;
                                hi_q <= rem_s;
                            end
`ifdef MULDIV_MADD_EN
                            MD_MADD, MD_MSUB: {hi_q, lo_q} <= madd_res;
`endif
                            default: ;
                        endcase
                    end
                    default: begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_o        = busy_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign divide_zero_o = divide_zero_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed corner cases plus random operations
// checked against an arithmetic HI/LO reference model.
module tb_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, en, start, cancel;
    logic [2:0]   oper;
    logic [W-1:0] a_in, b_in;
    logic         busy, dz;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] ref_hi, ref_lo;

    always #5 clk = ~clk;

    muldiv #(.DATA_BITS(W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .start_i       (start),
        .cancel_i      (cancel),
        .oper_i        (oper),
        .a_i           (a_in),
        .b_i           (b_in),
        .busy_o        (busy),
        .hi_o          (hi),
        .lo_o          (lo),
        .divide_zero_o (dz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_long(input logic [2:0] op, input logic [W-1:0] b);
        case (op)
            MD_MULT, MD_MULTU: return 1'b1;
            MD_DIV, MD_DIVU:   return b != '0;
`ifdef MULDIV_MADD_EN
            MD_MADD, MD_MSUB:  return 1'b1;
`endif
            default:           return 1'b0;
        endcase
    endfunction

    // Architectural effect of one operation, straight from 64-bit arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic signed [63:0] q, r;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            MD_MULT:  begin p = sa * sb; {ref_hi, ref_lo} = p; end
            MD_MULTU: begin p = ua * ub; {ref_hi, ref_lo} = p; end
            MD_DIV: if (b != '0) begin
                q = sa / sb;
                r = sa % sb;
                ref_lo = q[31:0];
                ref_hi = r[31:0];
            end
            MD_DIVU: if (b != '0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            MD_MTHI: ref_hi = a;
            MD_MTLO: ref_lo = a;
`ifdef MULDIV_MADD_EN
            MD_MADD: begin p = sa * sb; {ref_hi, ref_lo} = {ref_hi, ref_lo} + p; end
            MD_MSUB: begin p = sa * sb; {ref_hi, ref_lo} = {ref_hi, ref_lo} - p; end
`endif
            default: ;
        endcase
    endtask

    // Issues one op, counts busy/divide_zero cycles until idle, then compares HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int gap_at = -1, input int mtlo_at = -1);
        int busy_cnt, dz_cnt, exp_busy;
        bit exp_dz;
        exp_busy = model_long(op, b) ? (W + 1 + ((gap_at >= 0) ? 4 : 0)) : 0;
        exp_dz   = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);
        model_apply(op, a, b);
        @(negedge clk);
        start = 1'b1; oper = op; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        dz_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cnt++;
            if (dz) dz_cnt++;
            if (!busy && i >= 1) break;
            if (i == gap_at) en = 1'b0;
            if (i == gap_at + 4) en = 1'b1;
            if (i == mtlo_at) begin
                start = 1'b1; oper = MD_MTLO; a_in = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        en = 1'b1;
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, "_dz_cycles"}, 64'(dz_cnt), 64'(exp_dz));
        check({tag, "_hi"}, hi, ref_hi);
        check({tag, "_lo"}, lo, ref_lo);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] ra, rb;

        rst = 1'b1; en = 1'b1; start = 1'b0; cancel = 1'b0;
        oper = '0; a_in = '0; b_in = '0;
        ref_hi = '0; ref_lo = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_dz", dz, 0);
        rst = 1'b0;

        do_op("mult_neg3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", lo, 32'hFFFF_FFEB);

        do_op("divu_100_7", MD_DIVU, 32'd100, 32'd7);
        check("divu_lo_lit", lo, 32'd14);
        check("divu_hi_lit", hi, 32'd2);

        do_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_lit", lo, 32'hFFFF_FFFD);
        check("div_hi_lit", hi, 32'hFFFF_FFFF);

        do_op("mthi", MD_MTHI, 32'h11, 32'h0);
        do_op("mtlo", MD_MTLO, 32'h22, 32'h0);
        do_op("div_by_zero", MD_DIV, 32'd5, 32'd0);
        check("div0_hi_lit", hi, 32'h11);
        check("div0_lo_lit", lo, 32'h22);

        do_op("div_minneg", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("minneg_lo_lit", lo, 32'h8000_0000);
        check("minneg_hi_lit", hi, 32'h0);

        // Cancel ten cycles into a MULTU: HI/LO must keep pre-operation values.
        do_op("pre_cancel_hi", MD_MTHI, 32'hAA, 32'h0);
        do_op("pre_cancel_lo", MD_MTLO, 32'hBB, 32'h0);
        @(negedge clk);
        start = 1'b1; oper = MD_MULTU; a_in = 32'hFFFF_FFFF; b_in = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("cancel_busy_before", busy, 1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy_after", busy, 0);
        repeat (40) @(negedge clk);
        check("cancel_busy_later", busy, 0);
        check("cancel_hi", hi, 32'hAA);
        check("cancel_lo", lo, 32'hBB);

        // Same again with reset: everything clears.
        @(negedge clk);
        start = 1'b1; oper = MD_MULTU; a_in = 32'hFFFF_FFFF; b_in = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_hi = '0; ref_lo = '0;
        check("rst_busy_after", busy, 0);
        repeat (40) @(negedge clk);
        check("rst_busy_later", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        do_op("madd_pre_hi", MD_MTHI, 32'd0, 32'd0);
        do_op("madd_pre_lo", MD_MTLO, 32'd5, 32'd0);
        do_op("madd_2x3", MD_MADD, 32'd2, 32'd3);
`ifdef MULDIV_MADD_EN
        check("madd_lo_lit", lo, 32'd11);
`else
        check("madd_lo_lit", lo, 32'd5);
`endif
        check("madd_hi_lit", hi, 32'd0);

        do_op("divu_with_mtlo", MD_DIVU, 32'd1000, 32'd9, -1, 5);
        check("mtlo_ignored_lit", lo, 32'd111);
        do_op("mult_en_gap", MD_MULT, 32'd12345, 32'hFFFF_0001, 5, -1);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom());
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = 32'($urandom());
            endcase
            do_op($sformatf("rand%0d_op%0d", n, rop), rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
